serial_adder: RTL



---
 rtl/serial_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice (two half adders plus an OR)
// and a carry flop add two WIDTH-bit operands over WIDTH cycles.

module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             p;
  logic             g0;
  logic             g1;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] r_next;

  // Full-adder slice: propagate/generate from the operand bits, then fold in the carry.
  ha u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(p),     .c(g0));
  ha u_ha1 (.a(p),       .b(carry),   .s(s_bit), .c(g1));
  assign c_bit = g0 | g1;

  // r_sr keeps only the upper WIDTH-1 result bits; the new bit completes the word.
  assign r_next = {s_bit, r_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
      // default below and the later override in the same branch resolve to the last write.
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_next[WIDTH-1:1];
          carry <= c_bit;
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= r_next;
            cout  <= c_bit;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
